// File: rtl/bgpu_eu_dispatcher.sv
// Execution-unit dispatcher: per-EU round-robin arbitration of warp instructions
// into single-entry IU/LSU issue registers, with illegal-EU drop reporting.
module bgpu_eu_dispatcher #(
  parameter  int unsigned NumWarps     = 8,
  parameter  int unsigned PayloadWidth = 64,
  localparam int unsigned WidWidth     = $clog2(NumWarps)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,

  input  logic [NumWarps-1:0]              warp_valid_i,
  output logic [NumWarps-1:0]              warp_ready_o,
  input  logic [NumWarps*8-1:0]            warp_inst_i,
  input  logic [NumWarps*PayloadWidth-1:0] warp_payload_i,

  output logic                             iu_valid_o,
  input  logic                             iu_ready_i,
  output logic [5:0]                       iu_subtype_o,
  output logic [WidWidth-1:0]              iu_wid_o,
  output logic [PayloadWidth-1:0]          iu_payload_o,

  output logic                             lsu_valid_o,
  input  logic                             lsu_ready_i,
  output logic [5:0]                       lsu_subtype_o,
  output logic [WidWidth-1:0]              lsu_wid_o,
  output logic [PayloadWidth-1:0]          lsu_payload_o,

  output logic                             illegal_o,
  output logic [WidWidth-1:0]              illegal_wid_o
);

  typedef enum logic [1:0] {
    EU_IU  = 2'd0,
    EU_LSU = 2'd1
  } eu_e;

  logic [NumWarps-1:0]     w_iu_cand, w_lsu_cand, w_ill_cand;
  logic [WidWidth:0]       w_iu_pick, w_lsu_pick;
  logic                    w_ill_found;
  logic [WidWidth-1:0]     w_ill_idx;
  logic                    w_iu_go, w_lsu_go;
  logic [WidWidth-1:0]     w_iu_idx, w_lsu_idx;

  logic                    r_iu_valid, r_lsu_valid;
  logic [5:0]              r_iu_subtype, r_lsu_subtype;
  logic [WidWidth-1:0]     r_iu_wid, r_lsu_wid;
  logic [PayloadWidth-1:0] r_iu_payload, r_lsu_payload;
  logic [WidWidth-1:0]     r_iu_ptr, r_lsu_ptr;
  logic                    r_illegal;
  logic [WidWidth-1:0]     r_illegal_wid;

  // Returns {found, index} of the first candidate at or after ptr, wrapping.
  function automatic logic [WidWidth:0] rr_pick(input logic [NumWarps-1:0] cand,
                                                input logic [WidWidth-1:0] ptr);
    logic [WidWidth-1:0] idx;
    logic                found;
    found   = 1'b0;
    rr_pick = '0;
    for (int unsigned k = 0; k < NumWarps; k++) begin
      idx = ptr + WidWidth'(k);
      if (!found && cand[idx]) begin
        found   = 1'b1;
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  always_comb begin
    w_iu_cand  = '0;
    w_lsu_cand = '0;
    w_ill_cand = '0;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      if (warp_valid_i[w]) begin
        case (warp_inst_i[w*8+6 +: 2])
          EU_IU:   w_iu_cand[w]  = 1'b1;
          EU_LSU:  w_lsu_cand[w] = 1'b1;
          default: w_ill_cand[w] = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    w_ill_found = 1'b0;
    w_ill_idx   = '0;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      if (!w_ill_found && w_ill_cand[w]) begin
        w_ill_found = 1'b1;
        w_ill_idx   = WidWidth'(w);
      end
    end
  end

  assign w_iu_pick  = rr_pick(w_iu_cand, r_iu_ptr);
  assign w_lsu_pick = rr_pick(w_lsu_cand, r_lsu_ptr);
  assign w_iu_idx   = w_iu_pick[WidWidth-1:0];
  assign w_lsu_idx  = w_lsu_pick[WidWidth-1:0];
  // A register is free when empty or draining this cycle; reset blocks all grants.
  assign w_iu_go    = !rst_i && w_iu_pick[WidWidth]  && (!r_iu_valid  || iu_ready_i);
  assign w_lsu_go   = !rst_i && w_lsu_pick[WidWidth] && (!r_lsu_valid || lsu_ready_i);

  always_comb begin
    warp_ready_o = '0;
    if (w_iu_go)               warp_ready_o[w_iu_idx]  = 1'b1;
    if (w_lsu_go)              warp_ready_o[w_lsu_idx] = 1'b1;
    if (!rst_i && w_ill_found) warp_ready_o[w_ill_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_iu_valid    <= 1'b0;
      r_lsu_valid   <= 1'b0;
      r_iu_ptr      <= '0;
      r_lsu_ptr     <= '0;
      r_illegal     <= 1'b0;
      r_illegal_wid <= '0;
    end else begin
      if (w_iu_go) begin
        r_iu_valid   <= 1'b1;
        r_iu_subtype <= warp_inst_i[w_iu_idx*8 +: 6];
        r_iu_wid     <= w_iu_idx;
        r_iu_payload <= warp_payload_i[w_iu_idx*PayloadWidth +: PayloadWidth];
        r_iu_ptr     <= w_iu_idx + 1'b1;
      end else if (iu_ready_i) begin
        r_iu_valid   <= 1'b0;
      end
      if (w_lsu_go) begin
        r_lsu_valid   <= 1'b1;
        r_lsu_subtype <= warp_inst_i[w_lsu_idx*8 +: 6];
        r_lsu_wid     <= w_lsu_idx;
        r_lsu_payload <= warp_payload_i[w_lsu_idx*PayloadWidth +: PayloadWidth];
        r_lsu_ptr     <= w_lsu_idx + 1'b1;
      end else if (lsu_ready_i) begin
        r_lsu_valid   <= 1'b0;
      end
      r_illegal <= w_ill_found;
      if (w_ill_found) r_illegal_wid <= w_ill_idx;
    end
  end

  assign iu_valid_o    = r_iu_valid;
  assign iu_subtype_o  = r_iu_subtype;
  assign iu_wid_o      = r_iu_wid;
  assign iu_payload_o  = r_iu_payload;
  assign lsu_valid_o   = r_lsu_valid;
  assign lsu_subtype_o = r_lsu_subtype;
  assign lsu_wid_o     = r_lsu_wid;
  assign lsu_payload_o = r_lsu_payload;
  assign illegal_o     = r_illegal;
  assign illegal_wid_o = r_illegal_wid;

endmodule

// File: tb/tb_bgpu_eu_dispatcher.sv
// Directed bench for bgpu_eu_dispatcher (4 warps, 64-bit payload).
module tb_bgpu_eu_dispatcher;

  localparam int unsigned NW = 4;
  localparam int unsigned PW = 64;

  localparam logic [1:0] EU_IU  = 2'd0;
  localparam logic [1:0] EU_LSU = 2'd1;
  localparam logic [5:0] ADD    = 6'h01;
  localparam logic [5:0] ADDI   = 6'h02;
  localparam logic [5:0] LW     = 6'h10;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     valid;
  logic [NW-1:0]     ready;
  logic [NW*8-1:0]   inst;
  logic [NW*PW-1:0]  payload;
  logic              iu_valid, iu_ready, lsu_valid, lsu_ready, illegal;
  logic [5:0]        iu_sub, lsu_sub;
  logic [1:0]        iu_wid, lsu_wid, illegal_wid;
  logic [PW-1:0]     iu_pl, lsu_pl;
  logic [PW-1:0]     pl [NW];

  int vectors = 0;
  int miscompares = 0;

  bgpu_eu_dispatcher #(.NumWarps(NW), .PayloadWidth(PW)) dut (
    .clk_i(clk), .rst_i(rst),
    .warp_valid_i(valid), .warp_ready_o(ready),
    .warp_inst_i(inst), .warp_payload_i(payload),
    .iu_valid_o(iu_valid), .iu_ready_i(iu_ready), .iu_subtype_o(iu_sub),
    .iu_wid_o(iu_wid), .iu_payload_o(iu_pl),
    .lsu_valid_o(lsu_valid), .lsu_ready_i(lsu_ready), .lsu_subtype_o(lsu_sub),
    .lsu_wid_o(lsu_wid), .lsu_payload_o(lsu_pl),
    .illegal_o(illegal), .illegal_wid_o(illegal_wid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_warp(input int w, input logic v, input logic [1:0] eu, input logic [5:0] sub);
    valid[w]        = v;
    inst[w*8 +: 8]  = {eu, sub};
  endtask

  initial begin
    for (int w = 0; w < NW; w++) begin
      pl[w] = 64'hA5A5_0000_0000_0000 | 64'(w * 17 + 3);
      payload[w*PW +: PW] = pl[w];
    end
    rst = 1'b1; valid = '0; inst = '0; iu_ready = 1'b0; lsu_ready = 1'b0;

    // Reset state; grants suppressed while reset is held
    tick(); tick();
    for (int w = 0; w < NW; w++) set_warp(w, 1'b1, EU_IU, ADD);
    #1;
    check("rst_ready", 64'(ready), 64'h0);
    tick();
    check("rst_iu_valid", 64'(iu_valid), 64'h0);
    check("rst_lsu_valid", 64'(lsu_valid), 64'h0);
    check("rst_illegal", 64'(illegal), 64'h0);
    check("rst_illegal_wid", 64'(illegal_wid), 64'h0);

    // Fairness: all warps IU, ready high -> 0,1,2,3,0
    rst = 1'b0; iu_ready = 1'b1; lsu_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr_ready_%0d", k), 64'(ready), 64'(4'b0001 << (k % 4)));
      tick();
      check($sformatf("rr_valid_%0d", k), 64'(iu_valid), 64'h1);
      check($sformatf("rr_wid_%0d", k), 64'(iu_wid), 64'(k % 4));
      check($sformatf("rr_payload_%0d", k), iu_pl, pl[k % 4]);
    end
    valid = '0;
    tick();
    check("rr_drain", 64'(iu_valid), 64'h0);

    // Dual issue: warp1 IU ADDI, warp2 LSU LW (iu ptr=1, lsu ptr=0)
    set_warp(1, 1'b1, EU_IU, ADDI);
    set_warp(2, 1'b1, EU_LSU, LW);
    #1;
    check("dual_ready", 64'(ready), 64'h6);
    tick();
    valid = '0;
    check("dual_iu_valid", 64'(iu_valid), 64'h1);
    check("dual_iu_wid", 64'(iu_wid), 64'h1);
    check("dual_iu_sub", 64'(iu_sub), 64'(ADDI));
    check("dual_lsu_valid", 64'(lsu_valid), 64'h1);
    check("dual_lsu_wid", 64'(lsu_wid), 64'h2);
    check("dual_lsu_sub", 64'(lsu_sub), 64'(LW));
    check("dual_lsu_payload", lsu_pl, pl[2]);
    tick();
    check("dual_drain", 64'({iu_valid, lsu_valid}), 64'h0);

    // Backpressure: warp0 issued (iu ptr=2 wraps to 0), warp3 waits
    iu_ready = 1'b0;
    set_warp(0, 1'b1, EU_IU, ADD);
    #1;
    check("bp_ready0", 64'(ready), 64'h1);
    tick();
    set_warp(0, 1'b0, EU_IU, ADD);
    set_warp(3, 1'b1, EU_IU, ADDI);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_hold_ready_%0d", k), 64'(ready), 64'h0);
      check($sformatf("bp_hold_wid_%0d", k), 64'(iu_wid), 64'h0);
      check($sformatf("bp_hold_payload_%0d", k), iu_pl, pl[0]);
      check($sformatf("bp_hold_valid_%0d", k), 64'(iu_valid), 64'h1);
      tick();
    end
    iu_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(ready), 64'h8);
    tick();
    valid = '0;
    check("bp_w3_wid", 64'(iu_wid), 64'h3);
    check("bp_w3_payload", iu_pl, pl[3]);
    tick();
    check("bp_drain", 64'(iu_valid), 64'h0);

    // Illegal eu=3 on warp2
    set_warp(2, 1'b1, 2'd3, 6'h05);
    #1;
    check("ill_ready", 64'(ready), 64'h4);
    tick();
    valid = '0;
    check("ill_pulse", 64'(illegal), 64'h1);
    check("ill_wid", 64'(illegal_wid), 64'h2);
    check("ill_no_issue", 64'({iu_valid, lsu_valid}), 64'h0);
    tick();
    check("ill_pulse_end", 64'(illegal), 64'h0);

    // Two illegal warps: lowest index first
    set_warp(1, 1'b1, 2'd2, 6'h00);
    set_warp(3, 1'b1, 2'd3, 6'h00);
    #1;
    check("ill2_ready_a", 64'(ready), 64'h2);
    tick();
    set_warp(1, 1'b0, 2'd2, 6'h00);
    check("ill2_wid_a", 64'(illegal_wid), 64'h1);
    #1;
    check("ill2_ready_b", 64'(ready), 64'h8);
    tick();
    valid = '0;
    check("ill2_pulse_b", 64'(illegal), 64'h1);
    check("ill2_wid_b", 64'(illegal_wid), 64'h3);
    tick();

    // Reset mid-operation: lsu ptr=3 -> warp1 granted, then held
    lsu_ready = 1'b0;
    set_warp(1, 1'b1, EU_LSU, LW);
    tick();
    valid = '0;
    check("mid_lsu_valid", 64'(lsu_valid), 64'h1);
    check("mid_lsu_wid", 64'(lsu_wid), 64'h1);
    rst = 1'b1;
    for (int w = 0; w < NW; w++) set_warp(w, 1'b1, EU_LSU, LW);
    #1;
    check("mid_rst_ready", 64'(ready), 64'h0);
    tick();
    rst = 1'b0;
    check("mid_rst_lsu_valid", 64'(lsu_valid), 64'h0);
    lsu_ready = 1'b1;
    #1;
    check("mid_first_ready", 64'(ready), 64'h1);
    tick();
    valid = '0;
    check("mid_first_wid", 64'(lsu_wid), 64'h0);
    check("mid_first_valid", 64'(lsu_valid), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bgpu_eu_dispatcher.md
BGPU_EU_DISPATCHER -- requirements
Module: bgpu_eu_dispatcher

Interface
REQ-001 SHALL have parameter NumWarps, default 8, number of warp requesters (power of two, >=2).
REQ-002 SHALL have parameter PayloadWidth, default 64, opaque operand/destination payload width per instruction.
REQ-003 SHALL have localparam WidWidth = $clog2(NumWarps), the warp ID width.
REQ-004 SHALL have port clk_i, input, 1, the only clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port warp_valid_i, input, NumWarps, instruction valid per warp.
REQ-007 SHALL have port warp_ready_o, output, NumWarps, instruction accepted this cycle per warp.
REQ-008 SHALL have port warp_inst_i, input, NumWarps*8, inst_t per warp (eu in [7:6], subtype in [5:0]).
REQ-009 SHALL have port warp_payload_i, input, NumWarps*PayloadWidth, payload per warp.
REQ-010 SHALL have ports iu_valid_o (output, 1), iu_ready_i (input, 1), iu_subtype_o (output, 6), iu_wid_o (output, WidWidth) and iu_payload_o (output, PayloadWidth): IU issue port.
REQ-011 SHALL have ports lsu_valid_o, lsu_ready_i, lsu_subtype_o, lsu_wid_o and lsu_payload_o, with the same directions and widths: LSU issue port.
REQ-012 SHALL have ports illegal_o (output, 1) and illegal_wid_o (output, WidWidth): pulse and warp ID of a dropped instruction with an unknown eu.

Function
REQ-013 SHALL classify each valid warp w by eu: EU_IU (0) -> IU candidate, EU_LSU (1) -> LSU candidate, 2/3 -> illegal candidate.
REQ-014 SHALL hold one output register per EU; it is free when !x_valid_o || x_ready_i (combinational path from x_ready_i to warp_ready_o allowed).
REQ-015 SHALL run an independent round-robin arbiter per EU: grant = first candidate at index >= ptr, wrapping modulo NumWarps; grant only when that EU's register is free.
REQ-016 SHALL update ptr to (grant+1) mod NumWarps on a grant; ptr is unchanged without a grant.
REQ-017 SHALL allow up to one IU and one LSU grant in the same cycle (dual issue), to different warps.
REQ-018 SHALL assert warp_ready_o[w] only in the cycle w is granted; warp_ready_o[w] SHALL be 0 whenever warp_valid_i[w] is 0.
REQ-019 SHALL, on a grant at edge N, load subtype, wid and payload into the EU register and drive x_valid_o=1 from cycle N+1 (latency 1, throughput 1/cycle/EU).
REQ-020 SHALL hold x_subtype_o, x_wid_o and x_payload_o stable while x_valid_o && !x_ready_i.
REQ-021 SHALL clear x_valid_o after a handshake (x_valid_o && x_ready_i) unless a new grant loads the register in the same cycle.
REQ-022 SHALL accept the lowest-index illegal candidate each cycle (fixed priority, never blocked), assert its warp_ready_o, and pulse illegal_o=1 with illegal_wid_o for exactly one cycle next cycle; the instruction is not issued.
REQ-023 SHALL not reorder instructions of one warp: a warp has one instruction presented at a time, and the dispatcher never holds more than one instruction per EU.
REQ-024 SHALL keep payload and subtype outputs don't-care when x_valid_o=0.

Reset
REQ-025 SHALL, with rst_i=1 at an edge, clear iu_valid_o, lsu_valid_o and illegal_o to 0, set both ptrs to 0, and zero illegal_wid_o.
REQ-026 SHALL drive warp_ready_o all 0 during any cycle with rst_i=1; an in-flight registered instruction is discarded, not issued.

Verification (NumWarps=4, PayloadWidth=64)
REQ-027 SHALL verify fairness: warps 0-3 all valid with IU ADD and iu_ready_i=1 constantly -> iu_wid_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-028 SHALL verify dual issue: warp1 IU ADDI, warp2 LSU LOAD_WORD in the same cycle -> warp_ready_o=4'b0110, and the next cycle iu_wid_o=1 and lsu_wid_o=2 are both valid.
REQ-029 SHALL verify backpressure: iu_ready_i=0 for 3 cycles with warp0 issued and warp3 waiting -> iu_payload_o stable and warp_ready_o[3]=0; iu_ready_i=1 -> warp3 issues the next cycle.
REQ-030 SHALL verify illegal handling: warp2 with eu=3 -> warp_ready_o[2]=1, then illegal_o=1 and illegal_wid_o=2 for one cycle, with no IU/LSU valid.
REQ-031 SHALL verify reset mid-operation: lsu_valid_o=1 and lsu_ready_i=0, then rst_i=1 for 1 cycle -> lsu_valid_o=0 and, with all warps valid afterwards, the first LSU grant goes to warp 0.
